// File: rtl/ascon_perm_sched_2rc.sv
// ascon_perm_sched_2rc: round scheduler for an external 2-round-per-cycle
// ASCON permutation datapath (p12 / p8 / p6).
// Optional feature: define ASCON_SCHED_ABORT_EN to add an abort input that
// cancels a running permutation and returns to IDLE without a done pulse.
module ascon_perm_sched_2rc (
    input  logic         clk,
    input  logic         rst,
`ifdef ASCON_SCHED_ABORT_EN
    input  logic         abort,
`endif
    input  logic         start,
    input  logic [1:0]   rounds_sel,
    input  logic [319:0] state_in,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [319:0] state_out,
    output logic         dp_init,
    output logic         dp_inc,
    output logic [3:0]   dp_const,
    output logic [319:0] dp_xi,
    input  logic [319:0] dp_xo
);

    localparam int unsigned SW = 320;
    localparam int unsigned KW = 3;
    localparam int unsigned CW = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [KW-1:0] k, k_nxt;
    logic [KW-1:0] n_tgt, n_tgt_nxt;
    logic [SW-1:0] sout_nxt;
    logic [KW-1:0] n_sel;
    logic          abort_hit;
    logic          last_cyc;

    // First round index for a given two-round cycle count: 12 - 2N.
    function automatic logic [CW-1:0] const_of(input logic [KW-1:0] n);
        return CW'(5'd12 - {1'b0, n, 1'b0});
    endfunction

`ifdef ASCON_SCHED_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Cycle target from the round selection; the reserved code runs p12.
    always_comb begin
        case (rounds_sel)
            2'b01:   n_sel = KW'(4);
            2'b10:   n_sel = KW'(3);
            default: n_sel = KW'(6);
        endcase
    end

    // Final RUN cycle: the datapath output then carries all 2N rounds.
    assign last_cyc = ({1'b0, k} + 4'd1) >= {1'b0, n_tgt};

    // Next-state and output decode.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        n_tgt_nxt = n_tgt;
        sout_nxt  = state_out;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        dp_init   = 1'b0;
        dp_inc    = 1'b0;
        dp_const  = const_of(n_tgt);
        dp_xi     = '0;
        case (state)
            S_IDLE, S_DONE: begin
                ready = 1'b1;
                done  = (state == S_DONE);
                if (start) begin
                    n_tgt_nxt = n_sel;
                    k_nxt     = '0;
                    dp_const  = const_of(n_sel);
                    dp_xi     = state_in;
                    dp_init   = 1'b1;
                    state_nxt = S_LOAD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                busy = 1'b1;
                if (abort_hit) begin
                    k_nxt     = '0;
                    state_nxt = S_IDLE;
                end else begin
                    dp_xi     = dp_xo;
                    k_nxt     = KW'(1);
                    dp_inc    = (n_tgt > KW'(1));
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (abort_hit) begin
                    k_nxt     = '0;
                    state_nxt = S_IDLE;
                end else begin
                    dp_xi = dp_xo;
                    if (last_cyc) begin
                        sout_nxt  = dp_xo;
                        k_nxt     = n_tgt;
                        state_nxt = S_DONE;
                    end else begin
                        k_nxt  = k + KW'(1);
                        dp_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, counters and result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            k         <= '0;
            n_tgt     <= KW'(6);
            state_out <= '0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            n_tgt     <= n_tgt_nxt;
            state_out <= sout_nxt;
        end
    end

endmodule

// File: tb/tb_ascon_perm_sched_2rc.sv
// tb_ascon_perm_sched_2rc: random self-checking bench; hosts a 2-round ASCON
// datapath and compares results against a full-permutation reference.
module tb_ascon_perm_sched_2rc;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   rounds_sel;
    logic [319:0] state_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [319:0] state_out;
    logic         dp_init;
    logic         dp_inc;
    logic [3:0]   dp_const;
    logic [319:0] dp_xi;
    logic [319:0] dp_xo;
`ifdef ASCON_SCHED_ABORT_EN
    logic         abort;
`endif

    int n_tests;
    int n_fail;

    logic [319:0] dp_reg;
    logic [3:0]   rc_cnt;
    logic [3:0]   rc1;

    logic [319:0] q [4];
    logic [1:0]   sels [6] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
    logic [319:0] st;
    logic [319:0] last_res;
    logic         got;
    int           ndone;

    ascon_perm_sched_2rc dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ASCON_SCHED_ABORT_EN
        .abort      (abort),
`endif
        .start      (start),
        .rounds_sel (rounds_sel),
        .state_in   (state_in),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .state_out  (state_out),
        .dp_init    (dp_init),
        .dp_inc     (dp_inc),
        .dp_const   (dp_const),
        .dp_xi      (dp_xi),
        .dp_xo      (dp_xo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One ASCON round with round-constant byte rc.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] rc);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ {56'd0, rc};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Reference: the last nr rounds of the 12-round schedule.
    function automatic logic [319:0] ascon_p(input logic [319:0] s, input int nr);
        logic [319:0] v;
        v = s;
        for (int i = 12 - nr; i < 12; i++)
            v = ascon_round(v, 8'(((15 - i) << 4) | i));
        return v;
    endfunction

    function automatic int rounds_of(input logic [1:0] sel);
        case (sel)
            2'b01:   return 8;
            2'b10:   return 6;
            default: return 12;
        endcase
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        v = '0;
        for (int i = 0; i < 10; i++) v = {v[287:0], 32'($urandom())};
        return v;
    endfunction

    // Datapath: register loads dp_xi each cycle; output is two rounds of it.
    always_ff @(posedge clk) begin
        dp_reg <= dp_xi;
        if (dp_init)     rc_cnt <= dp_const;
        else if (dp_inc) rc_cnt <= rc_cnt + 4'd2;
    end

    assign rc1 = rc_cnt + 4'd1;

    // Combinational two-round datapath output.
    always_comb begin
        dp_xo = ascon_round(ascon_round(dp_reg, {~rc_cnt, rc_cnt}), {~rc1, rc1});
    end

    task automatic check(input string tag, input logic [319:0] got_v, input logic [319:0] exp_v);
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    // Issue a start right after a rising edge; returns just after the accept edge.
    task automatic start_op(input string tag, input logic [1:0] sel, input logic [319:0] s);
        start = 1'b1; rounds_sel = sel; state_in = s;
        @(negedge clk);
        check({tag, "_ready"}, 320'(ready), 320'(1));
        check({tag, "_init"}, 320'(dp_init), 320'(1));
        check({tag, "_const"}, 320'(dp_const), 320'(12 - rounds_of(sel)));
        check({tag, "_xi"}, dp_xi, s);
        @(posedge clk); #1;
        start = 1'b0;
        state_in = rand320();
        rounds_sel = 2'($urandom_range(3, 0));
    endtask

    // Follow a running permutation to its done pulse; optional ignored start at cycle poke.
    task automatic wait_done(input string tag, input logic [1:0] sel, input logic [319:0] s, input int poke);
        int nr = rounds_of(sel);
        int n = nr / 2;
        int busy_cyc = 0;
        int inc_cyc = 0;
        logic seen = 1'b0;
        logic [319:0] res;
        res = ascon_p(s, nr);
        for (int c = 1; c <= 20 && !seen; c++) begin
            if (poke != 0 && c == poke) begin
                start = 1'b1; rounds_sel = sel ^ 2'b10; state_in = rand320();
            end
            if (poke != 0 && c == poke + 1) start = 1'b0;
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check({tag, "_lat"}, 320'(c), 320'(n + 1));
                check({tag, "_res"}, state_out, res);
                check({tag, "_busy"}, 320'(busy_cyc), 320'(n));
                check({tag, "_inc"}, 320'(inc_cyc), 320'(n - 1));
            end else begin
                busy_cyc += int'(busy);
                inc_cyc += int'(dp_inc);
            end
            @(posedge clk); #1;
        end
        if (!seen) check({tag, "_timeout"}, 320'(0), 320'(1));
        @(negedge clk);
        check({tag, "_pulse"}, 320'(done), 320'(0));
        check({tag, "_hold"}, state_out, res);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 320'(ready), 320'(1));
        check({tag, "_busy"}, 320'(busy), 320'(0));
        check({tag, "_done"}, 320'(done), 320'(0));
        check({tag, "_init"}, 320'(dp_init), 320'(0));
        check({tag, "_inc"}, 320'(dp_inc), 320'(0));
        check({tag, "_const"}, 320'(dp_const), 320'(0));
        check({tag, "_xi"}, dp_xi, 320'(0));
        check({tag, "_sout"}, state_out, 320'(0));
    endtask

    // Count done pulses over a few idle cycles.
    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            cnt += int'(done);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b0; start = 1'b0; rounds_sel = 2'b00; state_in = '0;
`ifdef ASCON_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        #12;
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst = 1'b1;

        // p12 of the all-zero state
        start_op("p12z", 2'b00, 320'(0));
        wait_done("p12z", 2'b00, 320'(0), 0);

        // random states across all round selections
        for (int i = 0; i < 6; i++) begin
            st = rand320();
            start_op("rnd", sels[i], st);
            wait_done("rnd", sels[i], st, 0);
        end

        // start held high: a new p6 accepted in every DONE cycle
        for (int i = 0; i < 4; i++) q[i] = rand320();
        start = 1'b1; rounds_sel = 2'b10; state_in = q[0];
        @(posedge clk); #1;
        state_in = q[1];
        for (int j = 0; j < 3; j++) begin
            got = 1'b0;
            for (int c = 1; c <= 12 && !got; c++) begin
                @(negedge clk);
                if (done) begin
                    got = 1'b1;
                    check("b2b_lat", 320'(c), 320'(4));
                    check("b2b_res", state_out, ascon_p(q[j], 6));
                    check("b2b_init", 320'(dp_init), 320'(1));
                    check("b2b_xi", dp_xi, q[j + 1]);
                end
                @(posedge clk); #1;
            end
            if (!got) check("b2b_timeout", 320'(0), 320'(1));
            if (j < 2) state_in = q[j + 2];
        end
        start = 1'b0;
        wait_done("b2b_last", 2'b10, q[3], 0);

        // start pulsed mid-run with a different selection is ignored
        st = rand320();
        start_op("ign", 2'b00, st);
        wait_done("ign", 2'b00, st, 3);

        // reset in cycle 4 of p12
        st = rand320();
        start_op("mrst", 2'b00, st);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1 check_reset_outputs("mrst");
        @(posedge clk); #1;
        rst = 1'b1;
        count_done(8, ndone);
        check("mrst_nodone", 320'(ndone), 320'(0));
        st = rand320();
        start_op("post", 2'b00, st);
        wait_done("post", 2'b00, st, 0);
        last_res = ascon_p(st, 12);

`ifdef ASCON_SCHED_ABORT_EN
        // abort in cycle 3 returns to IDLE and keeps the prior result
        st = rand320();
        start_op("abt", 2'b00, st);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(negedge clk);
        check("abt_init", 320'(dp_init), 320'(0));
        check("abt_inc", 320'(dp_inc), 320'(0));
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abt_ready", 320'(ready), 320'(1));
        check("abt_busy", 320'(busy), 320'(0));
        check("abt_sout", state_out, last_res);
        @(posedge clk); #1;
        count_done(8, ndone);
        check("abt_nodone", 320'(ndone), 320'(0));
`endif

        check("final_hold", state_out, last_res);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ascon_perm_sched_2rc.md
ASCON_PERM_SCHED_2RC -- requirements
Module: ascon_perm_sched_2rc

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 start  input  1  request a permutation; sampled only when ready=1.
REQ-004 rounds_sel  input  2  00=12 rounds, 01=8, 10=6, 11=12 (reserved, treated as 00).
REQ-005 state_in  input  320  initial state {x0,x1,x2,x3,x4}, x0 in [319:256]; sampled with accepted start.
REQ-006 ready  output  1  high in IDLE and DONE.
REQ-007 busy  output  1  high in LOAD and RUN.
REQ-008 done  output  1  one-cycle pulse; state_out valid in that cycle.
REQ-009 state_out  output  320  permuted state, registered, held until next accepted start.
REQ-010 dp_init  output  1  loads dp_const into the datapath round-constant counter.
REQ-011 dp_inc  output  1  advances the datapath round-constant counter by two rounds.
REQ-012 dp_const  output  4  starting round index: 0 (12 rnd), 4 (8 rnd), 6 (6 rnd).
REQ-013 dp_xi  output  320  next-state input to the 2-round datapath register.
REQ-014 dp_xo  input  320  datapath output (two rounds applied to its register).

Function
REQ-015 Datapath contract: datapath register loads dp_xi every cycle; dp_xo is combinational two rounds of that register; round constant byte {~c,c}, c = counter nibble.
REQ-016 FSM states IDLE, LOAD, RUN, DONE; reset state IDLE.
REQ-017 IDLE/DONE with start=1: latch rounds_sel, set cycle target N = rounds/2 (6, 4 or 3), dp_xi=state_in, dp_init=1, go LOAD.
REQ-018 IDLE/DONE with start=0: IDLE stays IDLE; DONE goes IDLE; dp_xi=0, dp_init=0, dp_inc=0.
REQ-019 LOAD (1 cycle): dp_xi=dp_xo, cycle counter k=1, dp_inc=1 if N>1, go RUN.
REQ-020 RUN: dp_xi=dp_xo; k increments per cycle; dp_inc=1 while k<N; when k=N capture dp_xo into state_out, dp_inc=0, go DONE.
REQ-021 done=1 exactly in the DONE cycle; start-to-done latency N+1 cycles (7, 5, 4); first round of a back-to-back request may coincide with done.
REQ-022 start while busy=1 ignored, no queuing; rounds_sel and state_in changes while busy have no effect.
REQ-023 dp_const is combinational from rounds_sel during the accepting cycle and held from latched value otherwise.
REQ-024 k counter 3 bits, never wraps: cleared on accept, saturates at N.
REQ-025 state_out changes only at the RUN-final capture edge or reset.

Reset
REQ-026 rst=0 asynchronously forces IDLE, k=0, latched rounds=12, state_out=0; outputs ready=1, busy=0, done=0, dp_init=0, dp_inc=0, dp_const=0, dp_xi=0.
REQ-027 Reset mid-operation abandons the permutation with no done pulse; first start after release is accepted normally.

Configuration
REQ-028 Macro ASCON_SCHED_ABORT_EN: when defined, adds input abort (1 bit); abort=1 in LOAD or RUN returns to IDLE next edge, no done, state_out unchanged, dp_init/dp_inc low in that cycle; abort outranks start.
REQ-029 Without ASCON_SCHED_ABORT_EN: no abort port; a started permutation always completes.

Verification
REQ-030 Reset, then state_in=0, rounds_sel=00, start 1 cycle -> busy 6 cycles, done pulse at cycle 7, state_out equals golden ASCON-p12 of zero state.
REQ-031 rounds_sel=01 and 10 with random state -> done at cycle 5 and 4, dp_const 4 and 6 at accept, dp_inc high 3 and 2 cycles, state_out matches p8/p6.
REQ-032 start held high continuously, rounds_sel=10 -> new permutation accepted in every DONE cycle, done period 4 cycles, each result correct.
REQ-033 start pulsed at cycle 3 of a p12 run, rounds_sel toggled -> ignored, single done at cycle 7, result unchanged.
REQ-034 rst driven low at cycle 4 of p12 -> all outputs at reset values immediately, no done; next start yields correct result.
REQ-035 ASCON_SCHED_ABORT_EN defined, abort=1 at cycle 3 -> IDLE next edge, no done, prior state_out retained.
